// File: rtl/circle_scan_param.sv
// Grid scan for a circle: each candidate centre is tested with NRING rings of NPTS
// table-driven sample points. CIRCLE_EARLY_REJECT_EN stops a ring once it must fail.
module circle_scan_param #(
  parameter int unsigned CW      = 10,
  parameter int unsigned ORG_X   = 110,
  parameter int unsigned ORG_Y   = 110,
  parameter int unsigned STEP_SH = 2,
  parameter int unsigned GRID_W  = 95,
  parameter int unsigned GRID_H  = 56,
  parameter int unsigned NRING   = 3,
  parameter int unsigned NPTS    = 10,
  parameter int unsigned OW      = 6,
  parameter int unsigned CNTW    = 4,
  localparam int unsigned AW     = (NRING * NPTS > 1) ? $clog2(NRING * NPTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NRING*CNTW-1:0]  thr,
  output logic [AW-1:0]          ofs_addr,
  input  logic [OW-1:0]          ofs_x,
  input  logic [OW-1:0]          ofs_y,
  output logic                   pt_req,
  output logic [CW-1:0]          pt_x,
  output logic [CW-1:0]          pt_y,
  input  logic                   pt_ack,
  input  logic                   pt_pix,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CW-1:0]          circle_x,
  output logic [CW-1:0]          circle_y
);

  localparam int unsigned GXW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned GYW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned RW  = (NRING > 1) ? $clog2(NRING) : 1;
  localparam int unsigned PW  = (NPTS > 1) ? $clog2(NPTS) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, REQ, EVAL, NEXT, DONE, ERR
  } state_t;

  state_t          state;
  logic [GXW-1:0]  gx;
  logic [GYW-1:0]  gy;
  logic [RW-1:0]   ring;
  logic [PW-1:0]   point;
  logic [CNTW-1:0] hits;

  logic [CNTW-1:0] thr_cur;
  logic [CNTW-1:0] hits_nxt;
  logic [CW-1:0]   base_x;
  logic [CW-1:0]   base_y;
  logic            ring_pass;
  logic            last_pt;
  logic            last_ring;
  logic            last_pos;
  logic            reject;

  function automatic logic [AW-1:0] addr_of(input int unsigned r, input int unsigned p);
    return AW'(r * NPTS + p);
  endfunction

  assign thr_cur   = thr[int'(ring) * CNTW +: CNTW];
  assign hits_nxt  = hits + CNTW'(pt_pix);
  assign base_x    = CW'(ORG_X + (32'(gx) << STEP_SH));
  assign base_y    = CW'(ORG_Y + (32'(gy) << STEP_SH));
  assign ring_pass = (ring == '0) ? (hits >= thr_cur) : (hits <= thr_cur);
  assign last_pt   = (point == PW'(NPTS - 1));
  assign last_ring = (ring == RW'(NRING - 1));
  assign last_pos  = (gx == GXW'(GRID_W - 1)) && (gy == GYW'(GRID_H - 1));

`ifdef CIRCLE_EARLY_REJECT_EN
  // Ring 0 can no longer reach its minimum, or an outer ring already exceeds its maximum
  always_comb begin
    reject = 1'b0;
    if (ring == '0)
      reject = (int'(hits_nxt) + int'(NPTS - 1) - int'(point)) < int'(thr_cur);
    else
      reject = hits_nxt > thr_cur;
  end
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gx       <= '0;
      gy       <= '0;
      ring     <= '0;
      point    <= '0;
      hits     <= '0;
      ofs_addr <= '0;
      pt_req   <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      circle_x <= '0;
      circle_y <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          gx       <= '0;
          gy       <= '0;
          ring     <= '0;
          point    <= '0;
          hits     <= '0;
          ofs_addr <= '0;
          busy     <= 1'b1;
          state    <= ADDR;
        end
        ADDR: state <= WAIT;
        WAIT: begin
          pt_x   <= base_x + CW'(ofs_x);
          pt_y   <= base_y + CW'(ofs_y);
          pt_req <= 1'b1;
          state  <= REQ;
        end
        REQ: if (pt_ack) begin
          pt_req <= 1'b0;
          hits   <= hits_nxt;
          if (last_pt || reject) begin
            state <= EVAL;
          end else begin
            point    <= point + PW'(1);
            ofs_addr <= addr_of(32'(ring), 32'(point) + 1);
            state    <= ADDR;
          end
        end
        EVAL: begin
          if (!ring_pass) begin
            state <= NEXT;
          end else if (last_ring) begin
            state <= DONE;
          end else begin
            ring     <= ring + RW'(1);
            point    <= '0;
            hits     <= '0;
            ofs_addr <= addr_of(32'(ring) + 1, 0);
            state    <= ADDR;
          end
        end
        NEXT: begin
          ring     <= '0;
          point    <= '0;
          hits     <= '0;
          ofs_addr <= '0;
          if (last_pos) begin
            state <= ERR;
          end else begin
            if (gx == GXW'(GRID_W - 1)) begin
              gx <= '0;
              gy <= gy + GYW'(1);
            end else begin
              gx <= gx + GXW'(1);
            end
            state <= ADDR;
          end
        end
        DONE: begin
          circle_x <= base_x;
          circle_y <= base_y;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_scan_param.sv
// Directed bench for circle_scan_param on a reduced 6x4 grid with a synthetic pixel scene.
module tb_circle_scan_param;

  localparam int unsigned GW = 6;
  localparam int unsigned GH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] thr = 12'h733;
  logic [4:0]  ofs_addr;
  logic [5:0]  ofs_x, ofs_y;
  logic        pt_req, pt_ack, pt_pix;
  logic [9:0]  pt_x, pt_y;
  logic        busy, done, error;
  logic [9:0]  circle_x, circle_y;

  circle_scan_param #(.GRID_W(GW), .GRID_H(GH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .thr(thr),
    .ofs_addr(ofs_addr), .ofs_x(ofs_x), .ofs_y(ofs_y),
    .pt_req(pt_req), .pt_x(pt_x), .pt_y(pt_y), .pt_ack(pt_ack), .pt_pix(pt_pix),
    .busy(busy), .done(done), .error(error),
    .circle_x(circle_x), .circle_y(circle_y)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_req = 0, n_done = 0, n_err = 0, ev_base = 0;
  int stab_bad = 0, busy_bad = 0;
  int scene = 0;
  bit rand_dly = 0, resp_en = 1;
  logic man_ack = 1'b0, man_pix = 1'b0;
  logic [5:0] tbl_x [0:31];
  logic [5:0] tbl_y [0:31];

  // scene 0: all dark; 1: light ring-1/ring-2 arcs only around (118,114); 2: all light
  function automatic logic is_dark(input logic [9:0] x, input logic [9:0] y, input int sc);
    if (sc == 0) return 1'b1;
    if (sc == 2) return 1'b0;
    if (y == 10'd114 && x >= 10'd118 && x <= 10'd127) return 1'b0;
    if (y == 10'd174 && x >= 10'd168 && x <= 10'd177) return 1'b0;
    return 1'b1;
  endfunction

  // Offset table (1-cycle read latency) and pixel responder
  initial begin
    logic [4:0] lat_addr;
    logic [9:0] hx, hy;
    bit holding;
    int wait_cnt;
    lat_addr = '0; holding = 0; wait_cnt = 0; hx = '0; hy = '0;
    pt_ack = 1'b0; pt_pix = 1'b0; ofs_x = '0; ofs_y = '0;
    for (int k = 0; k < 32; k++) begin
      tbl_x[k] = '0; tbl_y[k] = '0;
    end
    for (int k = 0; k < 10; k++) begin
      tbl_x[k]      = 6'(30 + k); tbl_y[k]      = 6'd30;
      tbl_x[10 + k] = 6'(k);      tbl_y[10 + k] = 6'd0;
      tbl_x[20 + k] = 6'(50 + k); tbl_y[20 + k] = 6'd60;
    end
    forever begin
      @(negedge clk);
      ofs_x = tbl_x[lat_addr];
      ofs_y = tbl_y[lat_addr];
      lat_addr = ofs_addr;
      if (done) n_done++;
      if (error) n_err++;
      if ((done || error) && busy) busy_bad++;
      pt_ack = 1'b0;
      if (!resp_en) begin
        pt_ack = man_ack;
        pt_pix = man_pix;
        holding = 0;
      end else if (pt_req) begin
        if (!holding) begin
          holding = 1; hx = pt_x; hy = pt_y;
          wait_cnt = rand_dly ? int'($urandom_range(0, 5)) : 0;
        end else if (pt_x !== hx || pt_y !== hy) begin
          stab_bad++;
        end
        if (wait_cnt == 0) begin
          pt_ack = 1'b1;
          pt_pix = is_dark(pt_x, pt_y, scene);
          n_req++;
          holding = 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    ev_base = n_done + n_err;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 20000 && (n_done + n_err) == ev_base; i++) tick();
    tick();
    chk({tag, "_finished"}, 32'(n_done + n_err - ev_base), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_pt_req"}, 32'(pt_req), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_pt_x"}, 32'(pt_x), 32'd0);
    chk({tag, "_pt_y"}, 32'(pt_y), 32'd0);
    chk({tag, "_ofs_addr"}, 32'(ofs_addr), 32'd0);
    chk({tag, "_circle_x"}, 32'(circle_x), 32'd0);
    chk({tag, "_circle_y"}, 32'(circle_y), 32'd0);
  endtask

  initial begin
    int d0, e0;
    // Reset state
    tick(); tick();
    check_idle_zero("reset");
    rst_n = 1'b1;
    tick();

    // All dark: ring 1 fails everywhere -> error, 24 candidates x 20 requests
    scene = 0; n_req = 0; d0 = n_done;
    pulse_start();
    wait_result("dark");
    chk("dark_error_cnt", 32'(n_err - (ev_base - d0)), 32'd1);
    chk("dark_no_done", 32'(n_done - d0), 32'd0);
    chk("dark_circle_x", 32'(circle_x), 32'd0);
    chk("dark_circle_y", 32'(circle_y), 32'd0);
    chk("dark_req_cnt", 32'(n_req), 32'd480);

    // Scene with the circle at (gx=2, gy=1); also checks first-request timing
    scene = 1; n_req = 0; d0 = n_done;
    pulse_start();
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_addr0", 32'(ofs_addr), 32'd0);
    tick(); tick();
    chk("lat_req_hi", 32'(pt_req), 32'd1);
    chk("lat_pt_x", 32'(pt_x), 32'd140);
    chk("lat_pt_y", 32'(pt_y), 32'd140);
    tick();
    chk("lat_req_lo", 32'(pt_req), 32'd0);
    chk("lat_addr1", 32'(ofs_addr), 32'd1);
    wait_result("found");
    chk("found_done", 32'(n_done - d0), 32'd1);
    chk("found_circle_x", 32'(circle_x), 32'd118);
    chk("found_circle_y", 32'(circle_y), 32'd114);
    chk("found_req_cnt", 32'(n_req), 32'd190);
    chk("found_busy", 32'(busy), 32'd0);

    // Random ack delays plus a start pulse while busy
    rand_dly = 1; n_req = 0; d0 = n_done;
    pulse_start();
    repeat (60) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_busy", 32'(busy), 32'd1);
    wait_result("delay");
    chk("delay_done", 32'(n_done - d0), 32'd1);
    chk("delay_circle_x", 32'(circle_x), 32'd118);
    chk("delay_circle_y", 32'(circle_y), 32'd114);
    chk("delay_req_cnt", 32'(n_req), 32'd190);
    chk("delay_stable", 32'(stab_bad), 32'd0);
    rand_dly = 0;

    // Error leaves a previously found centre untouched
    scene = 0; n_req = 0; e0 = n_err;
    pulse_start();
    wait_result("dark2");
    chk("dark2_error", 32'(n_err - e0), 32'd1);
    chk("dark2_circle_x", 32'(circle_x), 32'd118);
    chk("dark2_circle_y", 32'(circle_y), 32'd114);

    // Reset while a request is pending, then a stale ack
    scene = 1; resp_en = 0; d0 = n_done; e0 = n_err;
    pulse_start();
    tick(); tick();
    chk("mid_req_hi", 32'(pt_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    tick();
    rst_n = 1'b1;
    man_pix = 1'b1; man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    repeat (4) tick();
    chk("late_ack_req", 32'(pt_req), 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_addr", 32'(ofs_addr), 32'd0);
    chk("late_ack_no_event", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    resp_en = 1; n_req = 0;
    pulse_start();
    wait_result("rerun");
    chk("rerun_circle_x", 32'(circle_x), 32'd118);
    chk("rerun_circle_y", 32'(circle_y), 32'd114);
    chk("rerun_req_cnt", 32'(n_req), 32'd190);

    // All light with thr[0]=7: ring 0 fails everywhere
    scene = 2; thr = 12'h737; n_req = 0; e0 = n_err;
    pulse_start();
    wait_result("light");
    chk("light_error", 32'(n_err - e0), 32'd1);
`ifdef CIRCLE_EARLY_REJECT_EN
    chk("light_req_cnt", 32'(n_req), 32'(GW * GH * 4));
`else
    chk("light_req_cnt", 32'(n_req), 32'(GW * GH * 10));
`endif
    chk("busy_low_on_result", 32'(busy_bad), 32'd0);
    chk("req_stable_all", 32'(stab_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
